// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential 2D convolution engine.
//   conv_state_e : FSM state encoding (IDLE=0 .. DONE=4), visible on state_o
//   idx_width    : ceil(log2(n)) with a floor of one bit, for index/select widths
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StMac  = 3'd2,
    StEmit = 3'd3,
    StDone = 3'd4
  } conv_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single unsigned multiply-accumulate stage.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clr_i          : zero the accumulator (wins over en_i)
//   en_i           : add a_i*b_i into the accumulator
//   a_i, b_i       : DW-bit unsigned operands
//   acc_o          : ACC_W-bit running sum
module mac_unit #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_q;

  assign prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
  assign acc_o = acc_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv2d_seq_engine.sv
// Valid-mode 2D correlation of an IMG_N x IMG_N image with a KER_K x KER_K kernel using one
// sequential MAC. Results stream out row-major over a valid/ready handshake.
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   run_i              : start request, level-sampled in IDLE and DONE
//   img_flat_i         : image, element (r,c) at [(r*IMG_N+c)*DW +: DW]
//   ker_flat_i         : kernel, element (i,j) at [(i*KER_K+j)*DW +: DW]
//   out_valid_o/ready_i: result handshake
//   out_data_o         : saturated (SAT=1) or truncated result
//   out_sat_o          : accumulator exceeded 2^OUT_W-1
//   out_row_o/col_o    : position of the presented result
//   busy_o, done_o     : LOAD/MAC/EMIT, DONE
//   state_o            : FSM encoding
module conv2d_seq_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_N = 4,
  parameter int unsigned KER_K = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SAT   = 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   run_i,
  input  logic [IMG_N*IMG_N*DW-1:0]              img_flat_i,
  input  logic [KER_K*KER_K*DW-1:0]              ker_flat_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [OUT_W-1:0]                       out_data_o,
  output logic                                   out_sat_o,
  output logic [idx_width(IMG_N-KER_K+1)-1:0]    out_row_o,
  output logic [idx_width(IMG_N-KER_K+1)-1:0]    out_col_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [2:0]                             state_o
);

  localparam int unsigned OUT_N    = IMG_N - KER_K + 1;
  localparam int unsigned ACC_W    = 2 * DW + $clog2(KER_K * KER_K);
  localparam int unsigned OW       = idx_width(OUT_N);
  localparam int unsigned KW       = idx_width(KER_K);
  localparam int unsigned IMG_BITS = IMG_N * IMG_N * DW;
  localparam int unsigned KER_BITS = KER_K * KER_K * DW;
  localparam int unsigned IB_W     = idx_width(IMG_BITS);
  localparam int unsigned KB_W     = idx_width(KER_BITS);
  localparam int unsigned EXT_W    = ACC_W + OUT_W;

  conv_state_e         state_q, state_d;
  logic [OW-1:0]       row_q, row_d, col_q, col_d;
  logic [KW-1:0]       i_q, i_d, j_q, j_d;
  logic [IMG_BITS-1:0] img_q;
  logic [KER_BITS-1:0] ker_q;
  logic                load_en, mac_clr, mac_en;
  logic [IB_W-1:0]     img_lsb;
  logic [KB_W-1:0]     ker_lsb;
  logic [DW-1:0]       pix, wgt;
  logic [ACC_W-1:0]    acc;
  logic [EXT_W-1:0]    acc_ext, max_ext;
  logic                over, last_res, emit;

  // Bit offsets of img[row+i][col+j] and ker[i][j] in the captured operand registers.
  assign img_lsb = IB_W'(((32'(row_q) + 32'(i_q)) * IMG_N + 32'(col_q) + 32'(j_q)) * DW);
  assign ker_lsb = KB_W'((32'(i_q) * KER_K + 32'(j_q)) * DW);
  assign pix     = img_q[img_lsb +: DW];
  assign wgt     = ker_q[ker_lsb +: DW];

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .a_i     (pix),
    .b_i     (wgt),
    .acc_o   (acc)
  );

  assign last_res = (row_q == OW'(OUT_N - 1)) && (col_q == OW'(OUT_N - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    i_d     = i_q;
    j_d     = j_q;
    load_en = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_i) state_d = StLoad;
      end
      StLoad: begin
        load_en = 1'b1;
        mac_clr = 1'b1;
        row_d   = '0;
        col_d   = '0;
        i_d     = '0;
        j_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        mac_en = 1'b1;
        if (j_q == KW'(KER_K - 1)) begin
          j_d = '0;
          if (i_q == KW'(KER_K - 1)) begin
            i_d     = '0;
            state_d = StEmit;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StEmit: begin
        if (out_ready_i) begin
          if (last_res) begin
            state_d = StDone;
          end else begin
            mac_clr = 1'b1;
            i_d     = '0;
            j_d     = '0;
            state_d = StMac;
            if (col_q == OW'(OUT_N - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        if (!run_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      img_q   <= '0;
      ker_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (load_en) begin
        img_q <= img_flat_i;
        ker_q <= ker_flat_i;
      end
    end
  end

  // Widen both sides so the overflow test also works when OUT_W >= ACC_W.
  assign acc_ext = EXT_W'(acc);
  assign max_ext = EXT_W'({OUT_W{1'b1}});
  assign over    = acc_ext > max_ext;
  assign emit    = (state_q == StEmit);

  // acc and the position counters are frozen in EMIT, so these are stable while stalled.
  assign out_valid_o = emit;
  assign out_sat_o   = emit & over;
  assign out_data_o  = !emit ? '0 : ((SAT != 0 && over) ? {OUT_W{1'b1}} : acc_ext[OUT_W-1:0]);
  assign out_row_o   = emit ? row_q : '0;
  assign out_col_o   = emit ? col_q : '0;
  assign busy_o      = (state_q == StLoad) || (state_q == StMac) || emit;
  assign done_o      = (state_q == StDone);
  assign state_o     = state_q;

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Self-checking bench: three engines (default SAT=1, SAT=0, 5x5/2x2) against a
// result-list plus cycle-countdown model, with literal pins on known data sets.
module tb_conv2d_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] run_v, rdy_v, valid_v, sat_v, busy_v, done_v;
  logic [127:0] img0, img1;
  logic [199:0] img2;
  logic [71:0]  ker0, ker1;
  logic [31:0]  ker2;
  logic [7:0]   data_a [3];
  logic [2:0]   state_a [3];
  logic [0:0]   row0, col0, row1, col1;
  logic [1:0]   row2, col2;

  int img_a [3][25];
  int ker_a [3][9];
  int cfg [3];
  int scnt [3];

  int total = 0;
  int bad   = 0;

  int t1i [16] = '{3, 1, 6, 5, 7, 5, 2, 7, 7, 10, 8, 9, 1, 3, 2, 10};
  int t1k [9]  = '{3, 1, 4, 0, 5, 1, 0, 1, 5};
  int t1e [4]  = '{111, 99, 105, 146};

  always_comb begin
    img0 = '0;
    img1 = '0;
    ker0 = '0;
    ker1 = '0;
    for (int k = 0; k < 16; k++) begin
      img0[k*8 +: 8] = img_a[0][k][7:0];
      img1[k*8 +: 8] = img_a[1][k][7:0];
    end
    for (int k = 0; k < 9; k++) begin
      ker0[k*8 +: 8] = ker_a[0][k][7:0];
      ker1[k*8 +: 8] = ker_a[1][k][7:0];
    end
  end

  always_comb begin
    img2 = '0;
    ker2 = '0;
    for (int k = 0; k < 25; k++) img2[k*8 +: 8] = img_a[2][k][7:0];
    for (int k = 0; k < 4; k++)  ker2[k*8 +: 8] = ker_a[2][k][7:0];
  end

  conv2d_seq_engine #(.IMG_N(4), .KER_K(3), .DW(8), .OUT_W(8), .SAT(1)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .run_i(run_v[0]), .img_flat_i(img0), .ker_flat_i(ker0),
    .out_valid_o(valid_v[0]), .out_ready_i(rdy_v[0]), .out_data_o(data_a[0]),
    .out_sat_o(sat_v[0]), .out_row_o(row0), .out_col_o(col0), .busy_o(busy_v[0]),
    .done_o(done_v[0]), .state_o(state_a[0])
  );

  conv2d_seq_engine #(.IMG_N(4), .KER_K(3), .DW(8), .OUT_W(8), .SAT(0)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .run_i(run_v[1]), .img_flat_i(img1), .ker_flat_i(ker1),
    .out_valid_o(valid_v[1]), .out_ready_i(rdy_v[1]), .out_data_o(data_a[1]),
    .out_sat_o(sat_v[1]), .out_row_o(row1), .out_col_o(col1), .busy_o(busy_v[1]),
    .done_o(done_v[1]), .state_o(state_a[1])
  );

  conv2d_seq_engine #(.IMG_N(5), .KER_K(2), .DW(8), .OUT_W(8), .SAT(1)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .run_i(run_v[2]), .img_flat_i(img2), .ker_flat_i(ker2),
    .out_valid_o(valid_v[2]), .out_ready_i(rdy_v[2]), .out_data_o(data_a[2]),
    .out_sat_o(sat_v[2]), .out_row_o(row2), .out_col_o(col2), .busy_o(busy_v[2]),
    .done_o(done_v[2]), .state_o(state_a[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int side(input int d);
    return (d == 2) ? 5 : 4;
  endfunction
  function automatic int kside(input int d);
    return (d == 2) ? 2 : 3;
  endfunction
  function automatic int satm(input int d);
    return (d == 1) ? 0 : 1;
  endfunction
  function automatic int act_row(input int d);
    case (d)
      0:       return int'(row0);
      1:       return int'(row1);
      default: return int'(row2);
    endcase
  endfunction
  function automatic int act_col(input int d);
    case (d)
      0:       return int'(col0);
      1:       return int'(col1);
      default: return int'(col2);
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 computing (countdown to next result), 2 presenting, 3 finished.
  typedef struct packed { int v; int s; int r; int c; } res_t;
  res_t mexp [3][16];
  int   mmode [3];
  int   mcnt [3];
  int   mhead [3];
  int   mtot [3];
  bit   mload [3];

  task automatic build(input int d);
    int n, k, on, idx, acc;
    n   = side(d);
    k   = kside(d);
    on  = n - k + 1;
    idx = 0;
    for (int r = 0; r < on; r++) begin
      for (int c = 0; c < on; c++) begin
        acc = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            acc += img_a[d][(r + i) * n + c + j] * ker_a[d][i * k + j];
        mexp[d][idx].s = (acc > 255) ? 1 : 0;
        mexp[d][idx].v = (acc > 255 && satm(d) == 1) ? 255 : acc % 256;
        mexp[d][idx].r = r;
        mexp[d][idx].c = c;
        idx++;
      end
    end
    mtot[d]  = on * on;
    mhead[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      mmode[d] = 0; mcnt[d] = 0; mhead[d] = 0; mtot[d] = 0; mload[d] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int d = 0; d < 3; d++) begin
        if (reset) begin
          mmode[d] = 0; mload[d] = 1'b0; mhead[d] = 0; mtot[d] = 0;
        end else begin
          case (mmode[d])
            0: if (run_v[d]) begin
              mmode[d] = 1; mload[d] = 1'b1; mcnt[d] = kside(d) * kside(d) + 1;
            end
            1: begin
              if (mload[d]) begin
                build(d);
                mload[d] = 1'b0;
              end
              mcnt[d]--;
              if (mcnt[d] == 0) mmode[d] = 2;
            end
            2: if (rdy_v[d]) begin
              mhead[d]++;
              if (mhead[d] == mtot[d]) mmode[d] = 3;
              else begin
                mmode[d] = 1; mcnt[d] = kside(d) * kside(d);
              end
            end
            default: if (!run_v[d]) mmode[d] = 0;
          endcase
        end
      end
    end
  end

  // ---------------- compare + capture ----------------
  int cyc = 0;
  int got_n [3];
  int got_v [3][32];
  int got_s [3][32];
  int got_r [3][32];
  int got_c [3][32];
  int rise_n [3];
  int rise_t [3][32];
  bit pv [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      got_n[d] = 0; rise_n[d] = 0; pv[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        int ev, est;
        ev  = (mmode[d] == 2) ? 1 : 0;
        est = (mmode[d] == 0) ? 0 : (mmode[d] == 1) ? (mload[d] ? 1 : 2) :
              (mmode[d] == 2) ? 3 : 4;
        chk($sformatf("d%0d_valid", d), int'(valid_v[d]), ev);
        chk($sformatf("d%0d_busy", d), int'(busy_v[d]), (mmode[d] == 1 || mmode[d] == 2) ? 1 : 0);
        chk($sformatf("d%0d_done", d), int'(done_v[d]), (mmode[d] == 3) ? 1 : 0);
        chk($sformatf("d%0d_state", d), int'(state_a[d]), est);
        if (ev == 1) begin
          chk($sformatf("d%0d_data", d), int'(data_a[d]), mexp[d][mhead[d]].v);
          chk($sformatf("d%0d_sat", d), int'(sat_v[d]), mexp[d][mhead[d]].s);
          chk($sformatf("d%0d_row", d), act_row(d), mexp[d][mhead[d]].r);
          chk($sformatf("d%0d_col", d), act_col(d), mexp[d][mhead[d]].c);
        end
        if (valid_v[d] && !pv[d] && rise_n[d] < 32) begin
          rise_t[d][rise_n[d]] = cyc;
          rise_n[d]++;
        end
        if (valid_v[d] && rdy_v[d] && got_n[d] < 32) begin
          got_v[d][got_n[d]] = int'(data_a[d]);
          got_s[d][got_n[d]] = int'(sat_v[d]);
          got_r[d][got_n[d]] = act_row(d);
          got_c[d][got_n[d]] = act_col(d);
          got_n[d]++;
        end
        pv[d] = valid_v[d];
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    for (int d = 0; d < 3; d++) scnt[d] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (cfg[d] < 0) rdy_v[d] = 1'($urandom_range(0, 1));
        else if (cfg[d] == 0) rdy_v[d] = 1'b1;
        else if (!valid_v[d]) begin
          rdy_v[d] = 1'b0; scnt[d] = 0;
        end else if (scnt[d] < cfg[d]) begin
          rdy_v[d] = 1'b0; scnt[d]++;
        end else rdy_v[d] = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill(input int d, input int iv, input int kv);
    for (int k = 0; k < 25; k++) img_a[d][k] = iv;
    for (int k = 0; k < 9; k++)  ker_a[d][k] = kv;
  endtask

  task automatic load_t1(input int d);
    for (int k = 0; k < 16; k++) img_a[d][k] = t1i[k];
    for (int k = 0; k < 9; k++)  ker_a[d][k] = t1k[k];
  endtask

  task automatic scribble(input bit [2:0] m);
    for (int d = 0; d < 3; d++) begin
      if (m[d]) begin
        for (int k = 0; k < 25; k++) img_a[d][k] = int'($urandom_range(0, 255));
        for (int k = 0; k < 9; k++)  ker_a[d][k] = int'($urandom_range(0, 255));
      end
    end
  endtask

  // Start the masked engines, wait for all to finish, hold run in DONE, then release.
  task automatic run_job(input bit [2:0] m, input int hold, input bit scrib, output int lat);
    int n, first;
    first = m[0] ? 0 : (m[1] ? 1 : 2);
    for (int d = 0; d < 3; d++) begin
      if (m[d]) begin
        got_n[d] = 0; rise_n[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    run_v = m;
    n = 0;
    while (!valid_v[first] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (scrib && n == 3) scribble(m);
    end
    lat = n;
    while ((done_v & m) != m && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("job_finished", int'(done_v & m), int'(m));
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    chk("held_run_stays_done", int'(state_a[first]), 4);
    run_v = 3'b000;
    @(posedge clk);
    #1;
    chk("run_drop_idle", int'(state_a[first]), 0);
  endtask

  initial begin
    int lat, n;
    reset = 1'b1;
    run_v = 3'b000;
    rdy_v = 3'b000;
    for (int d = 0; d < 3; d++) begin
      cfg[d] = 0;
      fill(d, 0, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state_a[0]), 0);
    chk("rst_valid", int'(valid_v), 0);
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done", int'(done_v), 0);
    chk("rst_data", int'(data_a[0]), 0);
    #1 reset = 1'b0;

    // Known data, ready always high.
    load_t1(0);
    run_job(3'b001, 3, 1'b0, lat);
    chk("t1_latency", lat, 11);
    chk("t1_count", got_n[0], 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_value", got_v[0][k], t1e[k]);
      chk("t1_row", got_r[0][k], k / 2);
      chk("t1_col", got_c[0][k], k % 2);
      chk("t1_sat", got_s[0][k], 0);
    end
    for (int k = 1; k < 4; k++) chk("t1_spacing", rise_t[0][k] - rise_t[0][k-1], 10);

    // Same data with five stall cycles per result.
    cfg[0] = 5;
    run_job(3'b001, 1, 1'b0, lat);
    chk("t2_count", got_n[0], 4);
    for (int k = 0; k < 4; k++) chk("t2_value", got_v[0][k], t1e[k]);
    cfg[0] = 0;

    // All-255 operands: saturate vs. truncate.
    fill(0, 255, 255);
    fill(1, 255, 255);
    run_job(3'b011, 1, 1'b0, lat);
    chk("t3_count_sat", got_n[0], 4);
    chk("t3_count_trunc", got_n[1], 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_sat_value", got_v[0][k], 255);
      chk("t3_sat_flag", got_s[0][k], 1);
      chk("t3_trunc_value", got_v[1][k], 9);
      chk("t3_trunc_flag", got_s[1][k], 1);
    end

    // 5x5 image, 2x2 kernel, all ones.
    fill(2, 1, 1);
    run_job(3'b100, 1, 1'b0, lat);
    chk("t4_latency", lat, 6);
    chk("t4_count", got_n[2], 16);
    for (int k = 0; k < 16; k++) begin
      chk("t4_value", got_v[2][k], 4);
      chk("t4_row", got_r[2][k], k / 4);
      chk("t4_col", got_c[2][k], k % 4);
    end
    for (int k = 1; k < 16; k++) chk("t4_spacing", rise_t[2][k] - rise_t[2][k-1], 5);

    // Asynchronous reset while the second result is being accumulated.
    load_t1(0);
    got_n[0] = 0;
    @(posedge clk);
    #1;
    run_v = 3'b001;
    n = 0;
    while (got_n[0] < 1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_first_result", got_n[0], 1);
    repeat (3) @(posedge clk);
    #1;
    run_v = 3'b000;
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_state", int'(state_a[0]), 0);
    chk("t5_rst_valid", int'(valid_v[0]), 0);
    chk("t5_rst_busy", int'(busy_v[0]), 0);
    chk("t5_rst_data", int'(data_a[0]), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    run_job(3'b001, 2, 1'b0, lat);
    chk("t5_count", got_n[0], 4);
    for (int k = 0; k < 4; k++) chk("t5_value", got_v[0][k], t1e[k]);

    // New operands after a held run; inputs trashed during MAC must not matter.
    fill(0, 2, 1);
    run_job(3'b001, 5, 1'b1, lat);
    chk("t6_count", got_n[0], 4);
    for (int k = 0; k < 4; k++) chk("t6_value", got_v[0][k], 18);

    // Random operands and random ready on all three engines.
    for (int it = 0; it < 4; it++) begin
      for (int d = 0; d < 3; d++) begin
        int lim;
        lim = (($urandom_range(0, 1)) == 0) ? 15 : 255;
        for (int k = 0; k < 25; k++) img_a[d][k] = int'($urandom_range(0, lim));
        for (int k = 0; k < 9; k++)  ker_a[d][k] = int'($urandom_range(0, lim));
        cfg[d] = -1;
      end
      run_job(3'b111, 1, 1'b0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2d_seq_engine.md
Name: conv2d_seq_engine

Overview:
Parametrised successor of the fixed 4x4-image / 3x3-kernel convolution top. It computes a valid-mode 2D convolution (correlation, no kernel flip) of an IMG_N x IMG_N unsigned image with a KER_K x KER_K unsigned kernel using one sequential MAC. Results stream out row-major over a valid/ready handshake, with per-result saturation and position tags. It sits between the operand registers and the display/readout logic.

Parameters:
IMG_N, 4, image side length (>= KER_K)
KER_K, 3, kernel side length (>= 1)
DW, 8, operand width (unsigned)
OUT_W, 8, output result width
SAT, 1, 1 = saturate to 2^OUT_W-1; 0 = truncate to low OUT_W bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
run  in  1  start request; level-sampled in IDLE
img_flat  in  IMG_N*IMG_N*DW  element (r,c) at bits [(r*IMG_N+c)*DW +: DW]
ker_flat  in  KER_K*KER_K*DW  element (i,j) at bits [(i*KER_K+j)*DW +: DW]
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  result value
out_sat  out  1  accumulator exceeded 2^OUT_W-1 (set in both SAT modes)
out_row  out  clog2(OUT_N)  result row index
out_col  out  clog2(OUT_N)  result column index
busy  out  1  high in LOAD, MAC and EMIT
done  out  1  high in DONE
state  out  3  current FSM state encoding

Behaviour:
- Derived: OUT_N = IMG_N-KER_K+1; ACC_W = 2*DW+clog2(KER_K*KER_K). Index widths are at least 1 bit.
- Reset (async): state=IDLE, all outputs 0, accumulator and counters cleared. Reset mid-operation aborts immediately; no partial result is emitted.
- FSM encodings: IDLE=0, LOAD=1, MAC=2, EMIT=3, DONE=4.
  - IDLE: run=1 -> LOAD.
  - LOAD: captures img_flat and ker_flat into internal registers in one cycle. Later input changes are ignored until the next LOAD. Clears row, col, i, j and acc. -> MAC.
  - MAC: one product per cycle, acc += img[row+i][col+j]*ker[i][j], with i/j scanning row-major. After term KER_K*KER_K-1 -> EMIT.
  - EMIT: out_valid=1. out_data, out_sat, out_row and out_col are registered and held stable until out_ready=1.
    - Handshake with the last result (row=col=OUT_N-1) -> DONE.
    - Any other handshake: advance col (wrap to 0 and increment row), clear acc and i/j -> MAC.
  - DONE: done=1. Stays in DONE while run=1; run=0 -> IDLE. A run held high therefore does not retrigger.
- Latency: run sampled high at edge t gives LOAD at t+1, MAC at t+2..t+1+K*K, first out_valid at t+2+K*K. Each further result costs K*K+1 cycles with out_ready held high.
- Output value:
  - SAT=1: out_data = acc > 2^OUT_W-1 ? all-ones : acc[OUT_W-1:0].
  - SAT=0: out_data = acc[OUT_W-1:0].
  - out_sat = (acc > 2^OUT_W-1) in both modes.
- out_ready is ignored outside EMIT. out_valid is never asserted outside EMIT.

Decomposition:
- Package conv_pkg: state enum (IDLE..DONE, 3-bit) and a clog2-style width helper function.
- One sub-module, mac_unit: DW x DW unsigned multiply, ACC_W accumulate, with clear and enable inputs.
- FSM, counters and operand registers stay in conv2d_seq_engine.

Test Plan:
1. Defaults, with image rows [3,1,6,5],[7,5,2,7],[7,10,8,9],[1,3,2,10], kernel rows [3,1,4],[0,5,1],[0,1,5], out_ready=1 -> results 111,99,105,146 in order (r,c)=(0,0),(0,1),(1,0),(1,1), all with out_sat=0. First out_valid 11 cycles after run is sampled; spacing is 10 cycles; then done=1 and state=4.
2. Same data with out_ready low for 5 cycles on each result -> out_data and tags held stable while stalled. Same four values, no duplicate or drop.
3. Image and kernel all 255, SAT=1 -> every result 255 with out_sat=1. With SAT=0 -> every result 9 (585225 mod 256) with out_sat=1.
4. IMG_N=5, KER_K=2, image and kernel all 1 -> 16 results of 4, tags walking (0,0)..(3,3). Period 5 cycles.
5. Reset asserted mid-MAC on the second result -> outputs 0 and state=0 asynchronously. A new run then gives the full correct sequence from (0,0).
6. run held high through DONE -> no restart. Drop run -> IDLE. Reassert run with changed inputs -> new results reflect the new inputs, and input changes made during MAC have no effect.
